// File: rtl/goertzel_coef_gen.sv
// Walks the NF-entry angle table and produces 2*cos(w) (Q3.29) and sin(w) (Q2.30)
// per bin with a one-iteration-per-cycle rotation CORDIC; tables hold until reset.
module goertzel_coef_gen #(
  parameter int NF   = 11,
  parameter int ITER = 24
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic                 angle_ready_i,
  input  logic [NF-1:0][31:0]  angle_i,
  output logic                 ready,
  output logic [NF-1:0][31:0]  coef_o,
  output logic [NF-1:0][31:0]  sin_o
);
  localparam int IW = (NF > 1) ? $clog2(NF) : 1;
  localparam logic [31:0] TWO_PI  = 32'd105414357;
  localparam logic [31:0] PI      = 32'd52707179;
  localparam logic [31:0] HALF_PI = 32'd26353589;
  localparam logic signed [31:0] KINV = 32'sd652032874;

  typedef enum logic [2:0] {IDLE, LOAD, REDUCE, FOLD, ROT, STORE, DONE} state_t;

  // atan(2^-i) in Q2.30; beyond i=9 it rounds to exactly 2^(30-i)
  function automatic logic signed [31:0] atan_rom(input logic [4:0] i);
    case (i)
      5'd0:    atan_rom = 32'sd843314857;
      5'd1:    atan_rom = 32'sd497837829;
      5'd2:    atan_rom = 32'sd263043837;
      5'd3:    atan_rom = 32'sd133525159;
      5'd4:    atan_rom = 32'sd67021687;
      5'd5:    atan_rom = 32'sd33543516;
      5'd6:    atan_rom = 32'sd16775851;
      5'd7:    atan_rom = 32'sd8388437;
      5'd8:    atan_rom = 32'sd4194283;
      5'd9:    atan_rom = 32'sd2097149;
      default: atan_rom = 32'sd1 <<< (5'd30 - i);
    endcase
  endfunction

  state_t state, nxt;
  logic [IW-1:0]      indx;
  logic [31:0]        th, th_sub, ang_sel, t1, t2;
  logic               f_s, f_c, sneg, cneg, d;
  logic [4:0]         it;
  logic signed [31:0] x, y, z, xs, ys, at;

  assign ang_sel = angle_i[indx];
  assign th_sub  = th - TWO_PI;
  // Quadrant fold to [0, pi/2]; equality with PI / HALF_PI deliberately stays unfolded
  assign f_s = th > PI;
  assign t1  = f_s ? (TWO_PI - th) : th;
  assign f_c = t1 > HALF_PI;
  assign t2  = f_c ? (PI - t1) : t1;

  assign d  = ~z[31];
  assign xs = x >>> it;
  assign ys = y >>> it;
  assign at = atan_rom(it);

  always_ff @(posedge clk) begin
    if (!rstn)   state <= IDLE;
    else if (en) state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (angle_ready_i) nxt = LOAD;
      LOAD:    nxt = (ang_sel >= TWO_PI) ? REDUCE : FOLD;
      REDUCE:  if (th_sub < TWO_PI) nxt = FOLD;
      FOLD:    nxt = ROT;
      ROT:     if (it == 5'(ITER - 1)) nxt = STORE;
      STORE:   nxt = (indx == IW'(NF - 1)) ? DONE : LOAD;
      DONE:    nxt = DONE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ready  <= 1'b0;
      coef_o <= '0;
      sin_o  <= '0;
      indx   <= '0;
      th     <= '0;
      x      <= '0;
      y      <= '0;
      z      <= '0;
      it     <= '0;
      sneg   <= 1'b0;
      cneg   <= 1'b0;
    end else if (en) begin
      case (state)
        LOAD:   th <= ang_sel;
        REDUCE: th <= th_sub;
        FOLD: begin
          sneg <= f_s;
          cneg <= f_c;
          z    <= signed'(t2 << 6);
          x    <= KINV;
          y    <= '0;
          it   <= '0;
        end
        ROT: begin
          x  <= d ? (x - ys) : (x + ys);
          y  <= d ? (y + xs) : (y - xs);
          z  <= d ? (z - at) : (z + at);
          it <= it + 5'd1;
        end
        STORE: begin
          // Q2.30 cos reinterpreted as Q3.29 is already 2*cos
          coef_o[indx] <= cneg ? -x : x;
          sin_o[indx]  <= sneg ? -y : y;
          if (indx != IW'(NF - 1)) indx <= indx + 1'b1;
        end
        DONE:   ready <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_goertzel_coef_gen.sv
// Directed bench: single-entry instance for fixed angles and latency, eleven-entry
// instance for table order, enable freezing and mid-run reset.
module tb_goertzel_coef_gen;
  localparam int NF = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn = 1'b0;
  logic en1 = 1'b0, ar1 = 1'b0, ready1;
  logic [0:0][31:0] ang1 = '0, coef1, sin1;
  logic en11 = 1'b0, ar11 = 1'b0, ready11;
  logic [NF-1:0][31:0] ang11, coef11, sin11;

  int total = 0, bad = 0;
  int wr_next = 0, rises = 0, cyc;
  logic pr = 1'b0;
  logic [NF-1:0][31:0] pc = '0, ps = '0;

  goertzel_coef_gen #(.NF(1), .ITER(24)) dut1 (
    .clk(clk), .rstn(rstn), .en(en1), .angle_ready_i(ar1), .angle_i(ang1),
    .ready(ready1), .coef_o(coef1), .sin_o(sin1));

  goertzel_coef_gen #(.NF(NF), .ITER(24)) dut11 (
    .clk(clk), .rstn(rstn), .en(en11), .angle_ready_i(ar11), .angle_i(ang11),
    .ready(ready11), .coef_o(coef11), .sin_o(sin11));

  // Reference: reduce by the same Q8.24 2pi constant, then real trig scaled to 2^30
  function automatic int model_cs(input logic [31:0] a, input bit want_sin);
    longint th;
    real w, v;
    th = longint'({32'b0, a}) % 64'sd105414357;
    w  = real'(th) / 16777216.0;
    v  = want_sin ? $sin(w) : $cos(w);
    return int'(v * 1073741824.0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input logic [31:0] got, input int exp);
    longint diff;
    bit ok;
    total++;
    diff = longint'($signed(got)) - longint'(exp);
    if (diff < 0) diff = -diff;
    ok = (diff <= 256);
    assert (ok === 1'b1) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d (+-256)", tag, $signed(got), exp);
    end
  endtask

  task automatic run1(input string tag, input logic [31:0] a, input int exp_cyc,
                      input logic [31:0] ec, input logic [31:0] es);
    int cnt;
    @(negedge clk); rstn = 1'b0; en1 = 1'b0; ar1 = 1'b0;
    @(negedge clk); rstn = 1'b1; ang1[0] = a; en1 = 1'b1; ar1 = 1'b1;
    cnt = 0;
    while (cnt < 200) begin
      @(posedge clk); cnt++; #1;
      if (ready1) break;
    end
    chk({tag, "_cycles"}, 32'(cnt), 32'(exp_cyc));
    chk_tol({tag, "_coef"}, coef1[0], int'($signed(ec)));
    chk_tol({tag, "_sin"}, sin1[0], int'($signed(es)));
  endtask

  // One clock of the 11-entry instance, watching write order, freezing and ready
  task automatic mon_step(input bit mon);
    @(posedge clk); #1;
    if (mon) begin
      for (int k = 0; k < NF; k++)
        if (coef11[k] !== pc[k] || sin11[k] !== ps[k]) begin
          chk("wr_order", 32'(k), 32'(wr_next));
          chk("wr_en", {31'b0, en11}, 32'd1);
          wr_next++;
        end
      if (ready11 && !pr) begin
        rises++;
        chk("rdy_after_last", 32'(wr_next), 32'(NF));
      end
      if (pr) chk("rdy_hold", {31'b0, ready11}, 32'd1);
    end
    pc = coef11; ps = sin11; pr = ready11;
  endtask

  task automatic chk_table(input string tag);
    for (int k = 0; k < NF; k++) begin
      chk_tol($sformatf("%s_coef%0d", tag, k), coef11[k], model_cs(ang11[k], 1'b0));
      chk_tol($sformatf("%s_sin%0d", tag, k), sin11[k], model_cs(ang11[k], 1'b1));
    end
  endtask

  initial begin
    ang11[0] = 32'd10000000;  ang11[1] = 32'd30000000;  ang11[2]  = 32'd52707179;
    ang11[3] = 32'd70000000;  ang11[4] = 32'd100000000; ang11[5]  = 32'd5000000;
    ang11[6] = 32'd122983417; ang11[7] = 32'hFFFF_FFFF; ang11[8]  = 32'd200000000;
    ang11[9] = 32'd26353588;  ang11[10] = 32'd300000000;

    // reset must win over a simultaneous start request
    rstn = 1'b0; en1 = 1'b1; ar1 = 1'b1; en11 = 1'b1; ar11 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready1", {31'b0, ready1}, 32'd0);
    chk("rst_coef1", coef1[0], 32'd0);
    chk("rst_sin1", sin1[0], 32'd0);
    chk("rst_ready11", {31'b0, ready11}, 32'd0);
    for (int k = 0; k < NF; k++) begin
      chk($sformatf("rst_coef11_%0d", k), coef11[k], 32'd0);
      chk($sformatf("rst_sin11_%0d", k), sin11[k], 32'd0);
    end

    run1("a0",     32'd0,         29, 32'h4000_0000, 32'h0000_0000);
    run1("ahalf",  32'd26353589,  29, 32'h0000_0000, 32'h4000_0000);
    run1("api",    32'd52707179,  29, 32'hC000_0000, 32'h0000_0000);
    run1("a3half", 32'd79060768,  29, 32'h0000_0000, 32'hC000_0000);
    run1("a2pi60", 32'd122983417, 30, 32'h2000_0000, 32'h376C_F5D1);

    // full table with enable toggling
    @(negedge clk); rstn = 1'b0; en11 = 1'b0; mon_step(1'b0);
    @(negedge clk); rstn = 1'b1; wr_next = 0; rises = 0;
    cyc = 0;
    while (!ready11 && cyc < 4000) begin
      @(negedge clk); en11 = ($urandom_range(0, 3) != 0);
      mon_step(1'b1); cyc++;
    end
    chk("A_ready", {31'b0, ready11}, 32'd1);
    repeat (20) begin
      @(negedge clk); en11 = ($urandom_range(0, 3) != 0);
      mon_step(1'b1);
    end
    chk("A_rises", 32'(rises), 32'd1);
    chk_table("A");

    // reset during the rotation of entry 5, then a clean rerun
    @(negedge clk); rstn = 1'b0; mon_step(1'b0);
    @(negedge clk); rstn = 1'b1; en11 = 1'b1; wr_next = 0; rises = 0;
    cyc = 0;
    while (wr_next < 5 && cyc < 1000) begin mon_step(1'b1); cyc++; end
    chk("B_five_written", 32'(wr_next), 32'd5);
    repeat (10) mon_step(1'b1);
    @(negedge clk); rstn = 1'b0; mon_step(1'b0);
    chk("B_rst_ready", {31'b0, ready11}, 32'd0);
    for (int k = 0; k < NF; k++) begin
      chk($sformatf("B_rst_coef%0d", k), coef11[k], 32'd0);
      chk($sformatf("B_rst_sin%0d", k), sin11[k], 32'd0);
    end
    @(negedge clk); rstn = 1'b1; wr_next = 0; rises = 0;
    cyc = 0;
    while (!ready11 && cyc < 1000) begin mon_step(1'b1); cyc++; end
    // 11*27 + 2 plus 44 reduction cycles across the table
    chk("B_cycles", 32'(cyc), 32'd343);
    chk("B_rises", 32'(rises), 32'd1);
    chk_table("B");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
